key_debounce: RTL and testbench

//   Front end for the KEY[3:0] push-buttons, feeding the address/write controller
//   of the memory viewer. Synchronises the raw active-low keys to CLOCK_50, filters

---
 rtl/key_debounce.sv | 189 ++++++++++++++++++
 tb/tb_key_debounce.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Push-button front end: per-key synchroniser, bounce-filter FSM and auto-repeat.
// Emits one-cycle press/release pulses and a debounced held level for each key.

module key_debounce_chan #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_pressed,
    output logic o_released,
    output logic o_held
);
    // state     | meaning
    // IDLE      | key up, waiting for a low sample
    // PRESS_CHK | key low, counting stable cycles before accepting the press
    // HELD      | press accepted, counting toward first repeat
    // REPEAT    | auto-repeat running, one pulse per period
    // REL_CHK   | key high, counting stable cycles before accepting the release
    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_CHK,
        S_HELD,
        S_REPEAT,
        S_REL_CHK
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic             RPT_ON   = (REPEAT_EN != 0);

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_pressed_nxt;
    logic             w_released_nxt;
    logic             w_held_nxt;
    logic             r_pressed;
    logic             r_released;
    logic             r_held;

    // Synchroniser idles high so a key stuck down through reset is seen as a fresh press.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_key_n;
            r_s2 <= r_s1;
        end
    end

    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_pressed_nxt  = 1'b0;
        w_released_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_s2) begin
                    w_state_nxt = S_PRESS_CHK;
                    w_cnt_nxt   = '0;
                end
            end
            S_PRESS_CHK: begin
                if (r_s2) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt   = S_HELD;
                    w_cnt_nxt     = '0;
                    w_pressed_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_HELD: begin
                if (r_s2) begin
                    w_state_nxt = S_REL_CHK;
                    w_cnt_nxt   = '0;
                end else if (RPT_ON && (r_cnt == DLY_LAST)) begin
                    w_state_nxt   = S_REPEAT;
                    w_cnt_nxt     = '0;
                    w_pressed_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_REPEAT: begin
                if (r_s2) begin
                    w_state_nxt = S_REL_CHK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == PER_LAST) begin
                    w_cnt_nxt     = '0;
                    w_pressed_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_REL_CHK: begin
                // A low sample here is release bounce; going back to HELD restarts the repeat delay.
                if (!r_s2) begin
                    w_state_nxt = S_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt    = S_IDLE;
                    w_cnt_nxt      = '0;
                    w_released_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_held_nxt = (w_state_nxt == S_HELD) || (w_state_nxt == S_REPEAT) ||
                        (w_state_nxt == S_REL_CHK);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
            r_held     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pressed  <= w_pressed_nxt;
            r_released <= w_released_nxt;
            r_held     <= w_held_nxt;
        end
    end

    assign o_pressed  = r_pressed;
    assign o_released = r_released;
    assign o_held     = r_held;
endmodule

module key_debounce #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] released,
    output logic [N_KEYS-1:0] held
);
    localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_ALL = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CNT_W   = ($clog2(MAX_ALL) < 1) ? 1 : $clog2(MAX_ALL);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_EN      (REPEAT_EN),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .CNT_W          (CNT_W)
        ) u_chan (
            .i_clk     (CLOCK_50),
            .i_rst     (rst),
            .i_key_n   (key_n[g]),
            .o_pressed (pressed[g]),
            .o_released(released[g]),
            .o_held    (held[g])
        );
    end
endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short timing parameters
// (debounce 4, repeat delay 20, repeat period 8).

module tb_key_debounce;
    logic       CLOCK_50;
    logic       rst;
    logic [3:0] key_n;
    logic [3:0] pressed;
    logic [3:0] released;
    logic [3:0] held;

    int n_chk  = 0;
    int n_fail = 0;

    key_debounce #(
        .N_KEYS         (4),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_EN      (1),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .rst     (rst),
        .key_n   (key_n),
        .pressed (pressed),
        .released(released),
        .held    (held)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [3:0] kn;
        logic [3:0] p;
        logic [3:0] r;
        logic [3:0] h;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input int e, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge %0d: got %b expected %b", name, e, act, exp);
        end
    endtask

    // Drive keys for the coming edge, then sample just after it.
    task automatic step(input logic [3:0] kn);
        key_n = kn;
        @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        // key0 clean press then release; key1 low for three samples only (bounce)
        tbl[0]  = '{4'b1100, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b1100, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b1100, 4'b0000, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b1110, 4'b0000, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b1110, 4'b0000, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b1110, 4'b0000, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b1110, 4'b0001, 4'b0000, 4'b0001};
        tbl[7]  = '{4'b1110, 4'b0000, 4'b0000, 4'b0001};
        tbl[8]  = '{4'b1110, 4'b0000, 4'b0000, 4'b0001};
        tbl[9]  = '{4'b1110, 4'b0000, 4'b0000, 4'b0001};
        tbl[10] = '{4'b1111, 4'b0000, 4'b0000, 4'b0001};
        tbl[11] = '{4'b1111, 4'b0000, 4'b0000, 4'b0001};
        tbl[12] = '{4'b1111, 4'b0000, 4'b0000, 4'b0001};
        tbl[13] = '{4'b1111, 4'b0000, 4'b0000, 4'b0001};
        tbl[14] = '{4'b1111, 4'b0000, 4'b0000, 4'b0001};
        tbl[15] = '{4'b1111, 4'b0000, 4'b0000, 4'b0001};
        tbl[16] = '{4'b1111, 4'b0000, 4'b0001, 4'b0000};
        tbl[17] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000};

        rst   = 1'b1;
        key_n = 4'b0000;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("reset_pressed", -1, pressed, 4'b0000);
        chk("reset_released", -1, released, 4'b0000);
        chk("reset_held", -1, held, 4'b0000);
        key_n = 4'b1111;
        @(negedge CLOCK_50);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(4'b1111);
            chk("idle_held", i, held, 4'b0000);
        end

        // Press/release and bounce table
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].kn);
            chk("tbl_pressed", i, pressed, tbl[i].p);
            chk("tbl_released", i, released, tbl[i].r);
            chk("tbl_held", i, held, tbl[i].h);
        end
        for (int i = 0; i < 3; i++) step(4'b1111);

        // key2: hold 60 cycles (repeats), 2-cycle release glitch at 60/61, clean release at 87
        for (int e = 0; e < 96; e++) begin
            logic [3:0] kn;
            logic       ep;
            kn = ((e == 60) || (e == 61) || (e >= 87)) ? 4'b1111 : 4'b1011;
            ep = (e == 6) || (e == 26) || (e == 34) || (e == 42) || (e == 50) ||
                 (e == 58) || (e == 84);
            step(kn);
            chk("rpt_pressed", e, pressed, {1'b0, ep, 2'b00});
            chk("rpt_released", e, released, {1'b0, (e == 93), 2'b00});
            chk("rpt_held", e, held, {1'b0, ((e >= 6) && (e < 93)), 2'b00});
        end
        for (int i = 0; i < 3; i++) step(4'b1111);

        // keys 0 and 3 together into REPEAT, then reset while still held
        for (int e = 0; e < 40; e++) begin
            logic ep;
            ep = (e == 6) || (e == 26) || (e == 34);
            step(4'b0110);
            chk("pair_pressed", e, pressed, ep ? 4'b1001 : 4'b0000);
            chk("pair_held", e, held, (e >= 6) ? 4'b1001 : 4'b0000);
        end
        rst = 1'b1;
        #1;
        chk("async_rst_held", 40, held, 4'b0000);
        chk("async_rst_pressed", 40, pressed, 4'b0000);
        chk("async_rst_released", 40, released, 4'b0000);
        repeat (2) @(posedge CLOCK_50);
        #1;
        chk("in_rst_held", 42, held, 4'b0000);
        @(negedge CLOCK_50);
        rst = 1'b0;
        for (int e = 0; e < 11; e++) begin
            step(4'b0110);
            chk("post_rst_pressed", e, pressed, (e == 6) ? 4'b1001 : 4'b0000);
            chk("post_rst_released", e, released, 4'b0000);
            chk("post_rst_held", e, held, (e >= 6) ? 4'b1001 : 4'b0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
